// File: rtl/edge_pulse_pkg.sv
// Shared constants and types for the edge_pulse_bank level-to-pulse converter.
// Provides edge-mode codes, the debounce state type and a max helper.
package edge_pulse_pkg;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_BOTH = 2;

  typedef enum logic {
    STABLE   = 1'b0,
    COUNTING = 1'b1
  } db_state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/edge_pulse_bank_debounce_ch.sv
// One channel: synchroniser -> debounce FSM -> pulse register (+ auto-repeat
// when EDGE_PULSE_BANK_AUTO_REPEAT_EN is defined and EDGE_MODE is rising).
// Ports: clk_i, rst_i (async high), lev_i raw level, level_o, pulse_o.
module debounce_ch
  import edge_pulse_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 650000,
  parameter int EDGE_MODE       = EDGE_RISE,
  parameter int REPEAT_DELAY    = 32500000,
  parameter int REPEAT_PERIOD   = 6500000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic lev_i,
  output logic level_o,
  output logic pulse_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  db_state_e              state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   pulse_q, pulse_d;
  logic                   accept;
  logic                   edge_hit;
  logic                   rep_fire;

  assign sync = sync_q[SYNC_STAGES-1];

  // A terminal count of zero (DEBOUNCE_CYCLES == 1) lets STABLE accept
  // directly on the first mismatch cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    accept  = 1'b0;
    unique case (state_q)
      STABLE: begin
        if (sync != level_q) begin
          if (cnt_q == TERM) begin
            level_d = sync;
            accept  = 1'b1;
          end else begin
            state_d = COUNTING;
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end
      COUNTING: begin
        if (sync == level_q) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TERM) begin
          state_d = STABLE;
          cnt_d   = '0;
          level_d = sync;
          accept  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    edge_hit = 1'b0;
    unique case (1'b1)
      (EDGE_MODE == EDGE_BOTH): edge_hit = accept;
      (EDGE_MODE == EDGE_FALL): edge_hit = accept & ~sync;
      default:                  edge_hit = accept & sync;
    endcase
  end

`ifdef EDGE_PULSE_BANK_AUTO_REPEAT_EN
  if (EDGE_MODE == EDGE_RISE) begin : g_rep
    localparam int RW = $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD) + 1);
    localparam logic [RW-1:0] DLY_T = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PER_T = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    logic          first_q, first_d;

    // Any accepted edge restarts or stops the repeat timer, so a repeat
    // never lands on a press pulse or on the release.
    always_comb begin
      rep_cnt_d = '0;
      first_d   = 1'b1;
      rep_fire  = 1'b0;
      if (!accept && level_q) begin
        if (rep_cnt_q == (first_q ? DLY_T : PER_T)) begin
          rep_fire = 1'b1;
          first_d  = 1'b0;
        end else begin
          rep_cnt_d = rep_cnt_q + 1'b1;
          first_d   = first_q;
        end
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        rep_cnt_q <= '0;
        first_q   <= 1'b1;
      end else begin
        rep_cnt_q <= rep_cnt_d;
        first_q   <= first_d;
      end
    end
  end else begin : g_norep
    assign rep_fire = 1'b0;
  end
`else
  assign rep_fire = 1'b0;
`endif

  assign pulse_d = edge_hit | rep_fire;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= '0;
      state_q <= STABLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], lev_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  assign level_o = level_q;
  assign pulse_o = pulse_q;

endmodule

// File: rtl/edge_pulse_bank.sv
// Multi-channel debounced level-to-pulse bank; optional auto-repeat via
// EDGE_PULSE_BANK_AUTO_REPEAT_EN. Ports: clock, reset, lev, level, pulse, any_pulse.
module edge_pulse_bank
  import edge_pulse_pkg::*;
#(
  parameter int N_CH            = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 650000,
  parameter int EDGE_MODE       = EDGE_RISE,
  parameter int REPEAT_DELAY    = 32500000,
  parameter int REPEAT_PERIOD   = 6500000
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N_CH-1:0] lev,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] pulse,
  output logic            any_pulse
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_ch #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .EDGE_MODE      (EDGE_MODE),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk_i  (clock),
      .rst_i  (reset),
      .lev_i  (lev[i]),
      .level_o(level[i]),
      .pulse_o(pulse[i])
    );
  end

  assign any_pulse = |pulse;

endmodule

// File: tb/tb_edge_pulse_bank.sv
// Directed bench for edge_pulse_bank: three instances (rise/fall/both)
// share stimulus; immediate assertions at each check point.
module tb_edge_pulse_bank;

  logic       clock;
  logic       reset;
  logic [3:0] lev;
  logic [3:0] level_r, pulse_r, level_f, pulse_f, level_b, pulse_b;
  logic       any_r, any_f, any_b;

  int n_assert;
  int n_fail;

  edge_pulse_bank #(
    .N_CH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(0),
    .REPEAT_DELAY(10), .REPEAT_PERIOD(5)
  ) dut (
    .clock(clock), .reset(reset), .lev(lev),
    .level(level_r), .pulse(pulse_r), .any_pulse(any_r)
  );

  edge_pulse_bank #(
    .N_CH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(1),
    .REPEAT_DELAY(10), .REPEAT_PERIOD(5)
  ) dut_f (
    .clock(clock), .reset(reset), .lev(lev),
    .level(level_f), .pulse(pulse_f), .any_pulse(any_f)
  );

  edge_pulse_bank #(
    .N_CH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(2),
    .REPEAT_DELAY(10), .REPEAT_PERIOD(5)
  ) dut_b (
    .clock(clock), .reset(reset), .lev(lev),
    .level(level_b), .pulse(pulse_b), .any_pulse(any_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs,
                     input logic [3:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_r(input string tag, input logic [3:0] el,
                       input logic [3:0] ep);
    chk({tag, "_level"}, level_r, el);
    chk({tag, "_pulse"}, pulse_r, ep);
    chk({tag, "_any"}, {3'b000, any_r}, {3'b000, |ep});
  endtask

  initial begin
    logic [3:0] el, ep, epb, epf;
    n_assert = 0;
    n_fail   = 0;
    reset    = 1'b1;
    lev      = 4'b0000;
    tick();
    tick();
    chk_r("reset", 4'b0000, 4'b0000);
    chk("reset_f_level", level_f, 4'b0000);
    chk("reset_b_pulse", pulse_b, 4'b0000);
    reset = 1'b0;
    tick();
    tick();

    // clean press then release
    lev = 4'b0001;
    for (int e = 0; e < 5; e++) begin
      tick();
      chk_r("press_wait", 4'b0000, 4'b0000);
    end
    tick();
    chk_r("press_e5", 4'b0001, 4'b0001);
    chk("press_e5_fall", pulse_f, 4'b0000);
    chk("press_e5_both", pulse_b, 4'b0001);
    tick();
    chk_r("press_e6", 4'b0001, 4'b0000);
    chk("press_e6_both", pulse_b, 4'b0000);
    lev = 4'b0000;
    for (int e = 0; e < 5; e++) begin
      tick();
      chk_r("rel_wait", 4'b0001, 4'b0000);
      chk("rel_wait_fall", pulse_f, 4'b0000);
    end
    tick();
    chk_r("rel_e5", 4'b0000, 4'b0000);
    chk("rel_e5_fall", pulse_f, 4'b0001);
    chk("rel_e5_fall_any", {3'b000, any_f}, 4'b0001);
    chk("rel_e5_both", pulse_b, 4'b0001);
    tick();
    chk("rel_e6_fall", pulse_f, 4'b0000);
    chk("rel_e6_both", pulse_b, 4'b0000);

    // glitch of 3 cycles rejected
    lev = 4'b0010;
    for (int e = 0; e < 3; e++) begin
      tick();
      chk_r("glitch_hi", 4'b0000, 4'b0000);
    end
    lev = 4'b0000;
    for (int e = 0; e < 8; e++) begin
      tick();
      chk_r("glitch_lo", 4'b0000, 4'b0000);
      chk("glitch_both", pulse_b, 4'b0000);
    end

    // 4-cycle high accepted, then falls back
    lev = 4'b0010;
    for (int e = 0; e < 4; e++) begin
      tick();
      chk_r("four_hi", 4'b0000, 4'b0000);
    end
    lev = 4'b0000;
    tick();
    chk_r("four_e4", 4'b0000, 4'b0000);
    tick();
    chk_r("four_e5", 4'b0010, 4'b0010);
    for (int e = 6; e < 9; e++) begin
      tick();
      chk_r("four_hold", 4'b0010, 4'b0000);
    end
    tick();
    chk_r("four_e9", 4'b0000, 4'b0000);
    chk("four_e9_both", pulse_b, 4'b0010);
    tick();
    tick();

    // all channels at once
    lev = 4'b1111;
    for (int e = 0; e < 5; e++) begin
      tick();
      chk_r("all_wait", 4'b0000, 4'b0000);
    end
    tick();
    chk_r("all_e5", 4'b1111, 4'b1111);
    tick();
    chk_r("all_e6", 4'b1111, 4'b0000);
    lev = 4'b0000;
    for (int e = 0; e < 5; e++) begin
      tick();
      chk_r("all_rel_wait", 4'b1111, 4'b0000);
    end
    tick();
    chk_r("all_rel_e5", 4'b0000, 4'b0000);
    chk("all_rel_fall", pulse_f, 4'b1111);
    tick();

    // reset while ch0 is accepted and ch1 is mid-count
    lev = 4'b0001;
    for (int e = 0; e < 5; e++) tick();
    tick();
    chk_r("pre_rst_e5", 4'b0001, 4'b0001);
    lev = 4'b0011;
    tick();
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk_r("rst_mid", 4'b0000, 4'b0000);
    chk("rst_mid_both_level", level_b, 4'b0000);
    tick();
    tick();
    reset = 1'b0;
    for (int e = 0; e < 5; e++) begin
      tick();
      chk_r("post_rst_wait", 4'b0000, 4'b0000);
    end
    tick();
    chk_r("post_rst_e5", 4'b0011, 4'b0011);
    tick();
    chk_r("post_rst_e6", 4'b0011, 4'b0000);
    lev = 4'b0000;
    for (int e = 0; e < 8; e++) tick();
    chk_r("post_rst_idle", 4'b0000, 4'b0000);

    // long hold on ch0: repeats only when the feature is built in
    lev = 4'b0001;
    for (int e = 0; e <= 40; e++) begin
      if (e == 30) lev = 4'b0000;
      tick();
      el  = (e >= 5 && e < 35) ? 4'b0001 : 4'b0000;
      ep  = (e == 5) ? 4'b0001 : 4'b0000;
      epb = (e == 5 || e == 35) ? 4'b0001 : 4'b0000;
      epf = (e == 35) ? 4'b0001 : 4'b0000;
`ifdef EDGE_PULSE_BANK_AUTO_REPEAT_EN
      if (e == 15 || e == 20 || e == 25 || e == 30) ep = 4'b0001;
`endif
      chk_r($sformatf("hold_e%0d", e), el, ep);
      chk($sformatf("hold_both_e%0d", e), pulse_b, epb);
      chk($sformatf("hold_fall_e%0d", e), pulse_f, epf);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
